// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU op encodings and
// the all-zero control bundle used for pipeline bubbles.
package mips_pkg;

  localparam int NB_INST     = 32;
  localparam int NB_REG_ADDR = 5;
  localparam int NB_ALU_OP   = 4;

  typedef enum logic [NB_ALU_OP-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic [NB_ALU_OP-1:0] alu_op;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
  } ctrl_t;

  // A bubble must never write a register or memory, so every control is zero.
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID -> EX operand/control bundle. The decode side is the master, the
// ID/EX register is the slave.
interface id_ex_operand_stage_if;
  import mips_pkg::*;

  logic                   i_valid;
  logic                   i_stall;
  logic                   i_flush;
  logic [NB_INST-1:0]     i_rs_data;
  logic [NB_INST-1:0]     i_rt_data;
  logic [NB_INST-1:0]     i_sign_extend;
  logic [NB_REG_ADDR-1:0] i_rs_addr;
  logic [NB_REG_ADDR-1:0] i_rt_addr;
  logic [NB_REG_ADDR-1:0] i_dst_addr;
  logic                   i_alu_src_a;
  logic                   i_alu_src_b;
  logic [NB_ALU_OP-1:0]   i_alu_op;
  logic                   i_reg_write;
  logic                   i_mem_read;
  logic                   i_mem_write;
  logic                   i_mem_to_reg;

  logic                   o_valid;
  logic [NB_INST-1:0]     o_rs_data;
  logic [NB_INST-1:0]     o_rt_data;
  logic [NB_INST-1:0]     o_sign_extend;
  logic [NB_REG_ADDR-1:0] o_rs_addr;
  logic [NB_REG_ADDR-1:0] o_rt_addr;
  logic [NB_REG_ADDR-1:0] o_dst_addr;
  logic                   o_alu_src_a;
  logic                   o_alu_src_b;
  logic [NB_ALU_OP-1:0]   o_alu_op;
  logic                   o_reg_write;
  logic                   o_mem_read;
  logic                   o_mem_write;
  logic                   o_mem_to_reg;
  logic                   o_load_use;

  modport master (
    output i_valid, i_stall, i_flush, i_rs_data, i_rt_data, i_sign_extend,
           i_rs_addr, i_rt_addr, i_dst_addr, i_alu_src_a, i_alu_src_b,
           i_alu_op, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
    input  o_valid, o_rs_data, o_rt_data, o_sign_extend, o_rs_addr,
           o_rt_addr, o_dst_addr, o_alu_src_a, o_alu_src_b, o_alu_op,
           o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_load_use
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_rs_data, i_rt_data, i_sign_extend,
           i_rs_addr, i_rt_addr, i_dst_addr, i_alu_src_a, i_alu_src_b,
           i_alu_op, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
    output o_valid, o_rs_data, o_rt_data, o_sign_extend, o_rs_addr,
           o_rt_addr, o_dst_addr, o_alu_src_a, o_alu_src_b, o_alu_op,
           o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_load_use
  );

endinterface

// File: rtl/id_ex_hazard_detect.sv
// Load-use comparator: a valid load in EX whose destination is read by the
// instruction in ID. Register 0 is hardwired and never hazards.
module id_ex_hazard_detect
  import mips_pkg::*;
(
  input  logic                   i_ex_valid,
  input  logic                   i_ex_mem_read,
  input  logic [NB_REG_ADDR-1:0] i_ex_dst_addr,
  input  logic [NB_REG_ADDR-1:0] i_id_rs_addr,
  input  logic [NB_REG_ADDR-1:0] i_id_rt_addr,
  output logic                   o_load_use
);

  assign o_load_use = i_ex_valid & i_ex_mem_read & (i_ex_dst_addr != '0) &
                      ((i_ex_dst_addr == i_id_rs_addr) | (i_ex_dst_addr == i_id_rt_addr));

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with stall, flush and valid tracking plus load-use
// detection. Define ID_EX_BUBBLE_COUNT_EN to add bubble/stall counters.
module id_ex_operand_stage
  import mips_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  id_ex_operand_stage_if.slave    bus
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [31:0]             o_bubble_count,
  output logic [31:0]             o_stall_count
`endif
);

  logic                   valid_q;
  logic [NB_INST-1:0]     rs_data_q, rt_data_q, sign_extend_q;
  logic [NB_REG_ADDR-1:0] rs_addr_q, rt_addr_q, dst_addr_q;
  ctrl_t                  ctrl_q;
  ctrl_t                  ctrl_d;
  logic                   load_bubble;

  assign ctrl_d = '{alu_src_a:  bus.i_alu_src_a,
                    alu_src_b:  bus.i_alu_src_b,
                    alu_op:     bus.i_alu_op,
                    reg_write:  bus.i_reg_write,
                    mem_read:   bus.i_mem_read,
                    mem_write:  bus.i_mem_write,
                    mem_to_reg: bus.i_mem_to_reg};

  // Flush overrides stall; an unstalled edge with no valid instruction is also a bubble.
  assign load_bubble = bus.i_flush | (~bus.i_stall & ~bus.i_valid);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || load_bubble) begin
      valid_q       <= 1'b0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      sign_extend_q <= '0;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      dst_addr_q    <= '0;
      ctrl_q        <= BUBBLE;
    end else if (!bus.i_stall) begin
      valid_q       <= 1'b1;
      rs_data_q     <= bus.i_rs_data;
      rt_data_q     <= bus.i_rt_data;
      sign_extend_q <= bus.i_sign_extend;
      rs_addr_q     <= bus.i_rs_addr;
      rt_addr_q     <= bus.i_rt_addr;
      dst_addr_q    <= bus.i_dst_addr;
      ctrl_q        <= ctrl_d;
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_rs_data     = rs_data_q;
  assign bus.o_rt_data     = rt_data_q;
  assign bus.o_sign_extend = sign_extend_q;
  assign bus.o_rs_addr     = rs_addr_q;
  assign bus.o_rt_addr     = rt_addr_q;
  assign bus.o_dst_addr    = dst_addr_q;
  assign bus.o_alu_src_a   = ctrl_q.alu_src_a;
  assign bus.o_alu_src_b   = ctrl_q.alu_src_b;
  assign bus.o_alu_op      = ctrl_q.alu_op;
  assign bus.o_reg_write   = ctrl_q.reg_write;
  assign bus.o_mem_read    = ctrl_q.mem_read;
  assign bus.o_mem_write   = ctrl_q.mem_write;
  assign bus.o_mem_to_reg  = ctrl_q.mem_to_reg;

  id_ex_hazard_detect u_hazard (
    .i_ex_valid    (valid_q),
    .i_ex_mem_read (ctrl_q.mem_read),
    .i_ex_dst_addr (dst_addr_q),
    .i_id_rs_addr  (bus.i_rs_addr),
    .i_id_rt_addr  (bus.i_rt_addr),
    .o_load_use    (bus.o_load_use)
  );

`ifdef ID_EX_BUBBLE_COUNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_bubble_count <= '0;
      o_stall_count  <= '0;
    end else begin
      if (load_bubble && (o_bubble_count != '1))
        o_bubble_count <= o_bubble_count + 32'd1;
      if (bus.i_stall && !bus.i_flush && (o_stall_count != '1))
        o_stall_count <= o_stall_count + 32'd1;
    end
  end
`endif

endmodule
